// File: rtl/mem_responder.sv
// Single-port word memory that answers strobe-driven read/write requests from a
// control unit with a one-cycle Mem_Ready handshake and a sticky protocol-error flag.
module mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int READ_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR_HOLD} state_t;

  state_t              state, next_state;
  logic [2:0]          wait_cnt, next_cnt;
  logic [ADDR_W-1:0]   rd_addr, next_rd_addr;
  logic [15:0]         next_data;
  logic                next_ready, next_err, mem_wr;
  logic [15:0]         mem [2**ADDR_W];

  // Upper address bits alias onto the same words, so they are deliberately dropped.
  generate
    if (ADDR_W < 16) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^ADDR[15:ADDR_W];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 3'd0;
      rd_addr     <= '0;
      Data_to_CPU <= 16'h0000;
      Mem_Ready   <= 1'b0;
      Err         <= 1'b0;
    end else begin
      state       <= next_state;
      wait_cnt    <= next_cnt;
      rd_addr     <= next_rd_addr;
      Data_to_CPU <= next_data;
      Mem_Ready   <= next_ready;
      Err         <= next_err;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = wait_cnt;
    next_rd_addr = rd_addr;
    next_data    = Data_to_CPU;
    next_ready   = 1'b0;
    next_err     = Err;
    mem_wr       = 1'b0;
    case (state)
      IDLE: begin
        // A write wins over a simultaneous read; the overlap is a protocol error.
        if (Mem_WE) begin
          mem_wr     = 1'b1;
          next_ready = 1'b1;
          next_state = WR_HOLD;
          if (Mem_OE) next_err = 1'b1;
        end else if (Mem_OE) begin
          next_rd_addr = ADDR[ADDR_W-1:0];
          next_cnt     = 3'(READ_WAIT);
          next_state   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (Mem_WE) next_err = 1'b1;
        if (!Mem_OE) begin
          next_cnt   = 3'd0;
          next_state = IDLE;
        end else if (wait_cnt <= 3'd1) begin
          next_cnt   = 3'd0;
          next_data  = mem[rd_addr];
          next_ready = 1'b1;
          next_state = RD_HOLD;
        end else begin
          next_cnt = wait_cnt - 3'd1;
        end
      end
      RD_HOLD: begin
        if (Mem_WE) next_err = 1'b1;
        if (!Mem_OE) next_state = IDLE;
      end
      WR_HOLD: begin
        if (!Mem_WE) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Array has no reset so its contents survive Reset_n.
  always_ff @(posedge Clk) begin
    if (mem_wr) mem[ADDR[ADDR_W-1:0]] <= Data_from_CPU;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench: instance a uses READ_WAIT=1, instance b uses READ_WAIT=3.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        oe_a, we_a, oe_b, we_b;
  logic [15:0] addr, wdata;
  logic [15:0] data_a, data_b;
  logic        ready_a, ready_b, err_a, err_b;

  int          checks = 0;
  int          errors = 0;
  int          ready_cnt;
  logic [15:0] model_a [256];
  logic [15:0] model_b [256];
  logic [15:0] rd_q [$];
  logic [15:0] last_a, last_b;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .READ_WAIT(1)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .Mem_OE(oe_a), .Mem_WE(we_a), .ADDR(addr),
    .Data_from_CPU(wdata), .Data_to_CPU(data_a), .Mem_Ready(ready_a), .Err(err_a)
  );

  mem_responder #(.ADDR_W(8), .READ_WAIT(3)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Mem_OE(oe_b), .Mem_WE(we_b), .ADDR(addr),
    .Data_from_CPU(wdata), .Data_to_CPU(data_b), .Mem_Ready(ready_b), .Err(err_b)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count a ready pulse and, for reads, compare against the oldest expected word.
  task automatic sample(input int which, input bit rd_only);
    logic        r;
    logic [15:0] d, exp;
    r = (which == 0) ? ready_a : ready_b;
    d = (which == 0) ? data_a : data_b;
    if (r === 1'b1) begin
      ready_cnt++;
      if (rd_only) begin
        if (rd_q.size() > 0) begin
          exp = rd_q.pop_front();
          check("read data", {16'h0, d}, {16'h0, exp});
          if (which == 0) last_a = exp; else last_b = exp;
        end else begin
          check("unexpected read ready", rd_q.size(), 1);
        end
      end
    end
  endtask

  task automatic access(input int which, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int cycles, input int exp_ready,
                        input string tag);
    addr  = a;
    wdata = d;
    if (which == 0) begin oe_a = rd; we_a = wr; end
    else            begin oe_b = rd; we_b = wr; end
    if (wr) begin
      if (which == 0) model_a[a[7:0]] = d; else model_b[a[7:0]] = d;
    end else if (rd && exp_ready > 0) begin
      rd_q.push_back((which == 0) ? model_a[a[7:0]] : model_b[a[7:0]]);
    end
    ready_cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      sample(which, rd && !wr);
    end
    if (which == 0) begin oe_a = 1'b0; we_a = 1'b0; end
    else            begin oe_b = 1'b0; we_b = 1'b0; end
    @(negedge clk);
    sample(which, rd && !wr);
    check({tag, " ready pulses"}, ready_cnt, exp_ready);
    rd_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    oe_a = 1'b0; we_a = 1'b0; oe_b = 1'b0; we_b = 1'b0;
    addr = 16'h0; wdata = 16'h0;
    last_a = 16'h0; last_b = 16'h0;
    repeat (2) @(negedge clk);
    check("reset data_a", {16'h0, data_a}, 32'h0);
    check("reset ready_a", {31'h0, ready_a}, 32'h0);
    check("reset err_a", {31'h0, err_a}, 32'h0);
    check("reset data_b", {16'h0, data_b}, 32'h0);
    check("reset err_b", {31'h0, err_b}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 1'b0, 1'b1, 16'h0012, 16'h1234, 1, 1, "write 0012");
    access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 2, 1, "read 0012");

    access(0, 1'b0, 1'b1, 16'h0105, 16'hBEEF, 1, 1, "write 0105");
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2, 1, "alias read 0005");
    check("alias err_a", {31'h0, err_a}, 32'h0);

    access(0, 1'b0, 1'b1, 16'h0005, 16'h5555, 1, 1, "overwrite 0005");
    check("write keeps data_a", {16'h0, data_a}, {16'h0, last_a});
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 2, 1, "reread 0005");

    access(1, 1'b0, 1'b1, 16'h0007, 16'h7777, 1, 1, "b write 0007");
    access(1, 1'b1, 1'b0, 16'h0007, 16'h0000, 4, 1, "b read 0007");
    access(1, 1'b0, 1'b1, 16'h0008, 16'h8888, 1, 1, "b write 0008");
    access(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 2, 0, "b abort");
    check("abort keeps data_b", {16'h0, data_b}, {16'h0, last_b});
    check("abort err_b", {31'h0, err_b}, 32'h0);
    access(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 4, 1, "b read after abort");

    // Write strobe raised while a read is waiting must be ignored but flagged.
    addr = 16'h0008;
    oe_b = 1'b1;
    rd_q.push_back(model_b[8'h08]);
    ready_cnt = 0;
    @(negedge clk);
    sample(1, 1'b1);
    we_b  = 1'b1;
    wdata = 16'h1111;
    repeat (3) begin
      @(negedge clk);
      sample(1, 1'b1);
    end
    oe_b = 1'b0; we_b = 1'b0;
    @(negedge clk);
    sample(1, 1'b1);
    check("we in read ready pulses", ready_cnt, 1);
    check("we in read err_b", {31'h0, err_b}, 32'h1);
    rd_q.delete();
    access(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 4, 1, "b read after ignored write");

    access(0, 1'b1, 1'b1, 16'h0003, 16'h00AA, 1, 1, "conflict");
    check("conflict err_a", {31'h0, err_a}, 32'h1);
    check("conflict keeps data_a", {16'h0, data_a}, {16'h0, last_a});
    @(negedge clk);
    check("err_a sticky", {31'h0, err_a}, 32'h1);
    access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2, 1, "read 0003");

    access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 10, 1, "long strobe");

    // Reset dropped between clock edges while instance a sits in RD_WAIT.
    addr = 16'h0105;
    oe_a = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async data_a", {16'h0, data_a}, 32'h0);
    check("async ready_a", {31'h0, ready_a}, 32'h0);
    check("async err_a", {31'h0, err_a}, 32'h0);
    check("async data_b", {16'h0, data_b}, 32'h0);
    check("async err_b", {31'h0, err_b}, 32'h0);
    @(negedge clk);
    check("no ready under reset", {31'h0, ready_a}, 32'h0);
    oe_a  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 2, 1, "post-reset read 0012");
    access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2, 1, "post-reset read 0003");
    check("post-reset err_a", {31'h0, err_a}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
